// File: rtl/rv32i_exec_mem_unit.sv
// Execute/memory slice of the rv32i single-cycle core.
//
// Holds the main decoder, the 32-bit ALU and a DEPTH x DATA_WIDTH data BRAM.
// Decode and ALU are purely combinational. Only the BRAM write is clocked.
//
// Ports
//   clk             rising-edge clock (BRAM write)
//   rst             asynchronous active-low reset; forces control outputs to idle values
//   instruction     current instruction word
//   rs1, rs2        register-file read data
//   immediate       sign-extended immediate (shape chosen by imm_src)
//   init_done       0: BRAM write port driven by init_*; 1: driven by the datapath
//   init_addr/dat/we   init write byte address, data and enable
//   debug_addr      byte address for the combinational debug read
//   debug_data      BRAM word at debug_addr
//   branch          next PC is the branch/jump target
//   imm_src         000 I, 001 S, 010 B, 011 U, 100 J
//   reg_write       register-file write enable
//   wrt_back_src    00 mem, 01 ALU, 10 pc+4, 11 U/jalr adder
//   second_add_src  00 LUI, 01 AUIPC, 10 JALR, 11 none
//   alu_results     ALU result, also the data address
//   alu_zero        alu_results == 0
//   mem_rdata       load data (0 when the instruction is not a load)

module rv32i_exec_mem_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instruction,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0] immediate,
    input  logic                  init_done,
    input  logic [9:0]            init_addr,
    input  logic [DATA_WIDTH-1:0] init_dat,
    input  logic                  init_we,
    input  logic [9:0]            debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data,
    output logic                  branch,
    output logic [2:0]            imm_src,
    output logic                  reg_write,
    output logic [1:0]            wrt_back_src,
    output logic [1:0]            second_add_src,
    output logic [DATA_WIDTH-1:0] alu_results,
    output logic                  alu_zero,
    output logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor,
        AluSll, AluSrl, AluSra, AluSlt, AluSltu
    } alu_op_e;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7_5;

    assign opcode  = instruction[6:0];
    assign func3   = instruction[14:12];
    assign func7_5 = instruction[30];

    // ------------------------------------------------------------------
    // Main decoder (ungated)
    // ------------------------------------------------------------------
    logic       dec_jump;
    logic       dec_is_branch;
    logic [2:0] dec_imm_src;
    logic       dec_reg_write;
    logic [1:0] dec_wb_src;
    logic [1:0] dec_sas;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       alu_src;
    alu_op_e    alu_op;

    // Shared R / I-ALU func3 decode; sub is only legal for R-type.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic f7_5,
                                         input logic is_r);
        unique case (f3)
            3'b000:  return (is_r && f7_5) ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return f7_5 ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    always_comb begin
        dec_jump      = 1'b0;
        dec_is_branch = 1'b0;
        dec_imm_src   = 3'b000;
        dec_reg_write = 1'b0;
        dec_wb_src    = 2'b01;
        dec_sas       = 2'b11;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        alu_src       = 1'b1;
        alu_op        = AluAdd;

        case (opcode)
            OpR: begin
                alu_src       = 1'b0;
                dec_reg_write = 1'b1;
                alu_op        = arith_op(func3, func7_5, 1'b1);
            end
            OpImm: begin
                dec_reg_write = 1'b1;
                alu_op        = arith_op(func3, func7_5, 1'b0);
            end
            OpLoad: begin
                dec_mem_read  = 1'b1;
                dec_wb_src    = 2'b00;
                dec_reg_write = 1'b1;
            end
            OpStore: begin
                dec_imm_src   = 3'b001;
                dec_mem_write = 1'b1;
            end
            OpBranch: begin
                dec_imm_src   = 3'b010;
                dec_is_branch = 1'b1;
                alu_src       = 1'b0;
                case (func3[2:1])
                    2'b00:   alu_op = AluSub;
                    2'b10:   alu_op = AluSlt;
                    2'b11:   alu_op = AluSltu;
                    default: alu_op = AluSub;
                endcase
            end
            OpLui: begin
                dec_imm_src   = 3'b011;
                dec_sas       = 2'b00;
                dec_wb_src    = 2'b11;
                dec_reg_write = 1'b1;
            end
            OpAuipc: begin
                dec_imm_src   = 3'b011;
                dec_sas       = 2'b01;
                dec_wb_src    = 2'b11;
                dec_reg_write = 1'b1;
            end
            OpJal: begin
                dec_imm_src   = 3'b100;
                dec_jump      = 1'b1;
                dec_wb_src    = 2'b10;
                dec_reg_write = 1'b1;
            end
            OpJalr: begin
                dec_sas       = 2'b10;
                dec_jump      = 1'b1;
                dec_wb_src    = 2'b10;
                dec_reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] operand2;
    logic [4:0]            shamt;

    assign operand2 = alu_src ? immediate : rs2;
    assign shamt    = operand2[4:0];

    always_comb begin
        alu_results = '0;
        unique case (alu_op)
            AluAdd:  alu_results = rs1 + operand2;
            AluSub:  alu_results = rs1 - operand2;
            AluAnd:  alu_results = rs1 & operand2;
            AluOr:   alu_results = rs1 | operand2;
            AluXor:  alu_results = rs1 ^ operand2;
            AluSll:  alu_results = rs1 << shamt;
            AluSrl:  alu_results = rs1 >> shamt;
            AluSra:  alu_results = DATA_WIDTH'($signed(rs1) >>> shamt);
            AluSlt:  alu_results = {{(DATA_WIDTH-1){1'b0}}, $signed(rs1) < $signed(operand2)};
            AluSltu: alu_results = {{(DATA_WIDTH-1){1'b0}}, rs1 < operand2};
            default: alu_results = '0;
        endcase
    end

    assign alu_zero = (alu_results == '0);

    // Branch condition kept apart from the decoder so the ALU feedback does
    // not form a combinational loop through one process.
    logic branch_taken;

    always_comb begin
        branch_taken = 1'b0;
        if (dec_is_branch) begin
            case (func3)
                3'b000:        branch_taken = alu_zero;
                3'b001:        branch_taken = !alu_zero;
                3'b100, 3'b110: branch_taken = alu_results[0];
                3'b101, 3'b111: branch_taken = !alu_results[0];
                default:       branch_taken = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Reset gating of control outputs (reset is asynchronous: no clock involved)
    // ------------------------------------------------------------------
    logic mem_read;
    logic mem_write;

    always_comb begin
        branch         = 1'b0;
        imm_src        = 3'b000;
        reg_write      = 1'b0;
        wrt_back_src   = 2'b01;
        second_add_src = 2'b11;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        if (rst) begin
            branch         = dec_jump | branch_taken;
            imm_src        = dec_imm_src;
            reg_write      = dec_reg_write;
            wrt_back_src   = dec_wb_src;
            second_add_src = dec_sas;
            mem_read       = dec_mem_read;
            mem_write      = dec_mem_write;
        end
    end

    // ------------------------------------------------------------------
    // Data BRAM: synchronous write, combinational reads
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic [AW-1:0]         rd_idx;
    logic [AW-1:0]         dbg_idx;

    // Upper address bits are dropped so high addresses alias low words.
    assign rd_idx  = alu_results[AW+1:2];
    assign dbg_idx = AW'(debug_addr[9:2]);

    always_comb begin
        if (init_done) begin
            wr_idx  = alu_results[AW+1:2];
            wr_data = rs2;
            wr_en   = mem_write;
        end else begin
            wr_idx  = AW'(init_addr[9:2]);
            wr_data = init_dat;
            wr_en   = init_we & rst;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign mem_rdata  = mem_read ? mem[rd_idx] : '0;
    assign debug_data = mem[dbg_idx];

    logic unused_bits;
    assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7],
                           init_addr[1:0], debug_addr[1:0]};

endmodule

// File: tb/tb_rv32i_exec_mem_unit.sv
// Directed self-checking bench for rv32i_exec_mem_unit.
module tb_rv32i_exec_mem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction, rs1, rs2, immediate;
    logic        init_done;
    logic [9:0]  init_addr;
    logic [31:0] init_dat;
    logic        init_we;
    logic [9:0]  debug_addr;
    logic [31:0] debug_data;
    logic        branch;
    logic [2:0]  imm_src;
    logic        reg_write;
    logic [1:0]  wrt_back_src, second_add_src;
    logic [31:0] alu_results;
    logic        alu_zero;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32i_exec_mem_unit dut (
        .clk            (clk),
        .rst            (rst),
        .instruction    (instruction),
        .rs1            (rs1),
        .rs2            (rs2),
        .immediate      (immediate),
        .init_done      (init_done),
        .init_addr      (init_addr),
        .init_dat       (init_dat),
        .init_we        (init_we),
        .debug_addr     (debug_addr),
        .debug_data     (debug_data),
        .branch         (branch),
        .imm_src        (imm_src),
        .reg_write      (reg_write),
        .wrt_back_src   (wrt_back_src),
        .second_add_src (second_add_src),
        .alu_results    (alu_results),
        .alu_zero       (alu_zero),
        .mem_rdata      (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] op);
        return {f7, 5'd0, 5'd0, f3, 5'd0, op};
    endfunction

    // Step to just after the next rising edge; samples then happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm);
        instruction = ins;
        rs1         = a;
        rs2         = b;
        immediate   = imm;
        #2;
    endtask

    localparam logic [6:0] OpR = 7'b0110011, OpImm = 7'b0010011, OpLoad = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011, OpBranch = 7'b1100011, OpJal = 7'b1101111;

    initial begin
        rst = 1'b0; init_done = 1'b0; init_we = 1'b0; init_addr = '0; init_dat = '0;
        debug_addr = '0;
        apply(mk(7'd0, 3'b000, OpJal), 32'd0, 32'd0, 32'd0);

        // Reset values with a jump on the instruction bus
        check_eq("rst_branch", {31'd0, branch}, 32'd0);
        check_eq("rst_rw", {31'd0, reg_write}, 32'd0);
        check_eq("rst_imm_src", {29'd0, imm_src}, 32'd0);
        check_eq("rst_wb", {30'd0, wrt_back_src}, 32'd1);
        check_eq("rst_sas", {30'd0, second_add_src}, 32'd3);
        tick();
        rst = 1'b1;

        // Shifts
        apply(mk(7'd0, 3'b001, OpImm), 32'h15, 32'd0, 32'd1);
        check_eq("slli1", alu_results, 32'h2A);
        check_eq("slli1_wb", {30'd0, wrt_back_src}, 32'd1);
        check_eq("slli1_rw", {31'd0, reg_write}, 32'd1);
        apply(mk(7'd0, 3'b001, OpImm), 32'h15, 32'd0, 32'd3);
        check_eq("slli3", alu_results, 32'hA8);
        apply(mk(7'd0, 3'b101, OpImm), 32'h15, 32'd0, 32'd3);
        check_eq("srli3", alu_results, 32'h2);
        apply(mk(7'd0, 3'b101, OpImm), 32'h15, 32'd0, 32'd1);
        check_eq("srli1", alu_results, 32'hA);
        apply(mk(7'd0, 3'b001, OpImm), 32'hFFFFFFEB, 32'd0, 32'd1);
        check_eq("slli_neg", alu_results, 32'hFFFFFFD6);
        apply(mk(7'b0100000, 3'b101, OpImm), 32'hFFFFFFEB, 32'd0, 32'h401);
        check_eq("srai_neg", alu_results, 32'hFFFFFFF5);
        apply(mk(7'd0, 3'b101, OpImm), 32'hFFFFFFEB, 32'd0, 32'd1);
        check_eq("srli_neg", alu_results, 32'h7FFFFFF5);
        apply(mk(7'b0100000, 3'b000, OpR), 32'd10, 32'd3, 32'd100);
        check_eq("sub_r", alu_results, 32'd7);

        // BRAM init through the init port
        for (int i = 0; i < 3; i++) begin
            init_addr = 10'(i * 4);
            init_dat  = 32'h11111111 * (i + 1);
            init_we   = 1'b1;
            tick();
        end
        init_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            debug_addr = 10'(i * 4);
            #1;
            check_eq($sformatf("init_word%0d", i), debug_data, 32'h11111111 * (i + 1));
        end

        // Store at 8, old word visible until the edge, then load it back
        init_done  = 1'b1;
        debug_addr = 10'd8;
        apply(mk(7'd0, 3'b010, OpStore), 32'd4, 32'hDEADBEEF, 32'd4);
        check_eq("sw_imm_src", {29'd0, imm_src}, 32'd1);
        check_eq("sw_addr", alu_results, 32'd8);
        check_eq("sw_old_word", debug_data, 32'h33333333);
        check_eq("sw_no_rdata", mem_rdata, 32'd0);
        tick();
        apply(mk(7'd0, 3'b010, OpLoad), 32'd0, 32'd0, 32'd8);
        check_eq("lw_data", mem_rdata, 32'hDEADBEEF);
        check_eq("lw_wb", {30'd0, wrt_back_src}, 32'd0);

        // Alias: 0x1008 maps to word 2
        apply(mk(7'd0, 3'b010, OpStore), 32'h1000, 32'hCAFEF00D, 32'd8);
        tick();
        check_eq("alias_word2", debug_data, 32'hCAFEF00D);
        debug_addr = 10'd0;
        #1;
        check_eq("alias_word0", debug_data, 32'h11111111);

        // Branches
        apply(mk(7'd0, 3'b000, OpBranch), 32'd5, 32'd5, 32'd0);
        check_eq("beq_taken", {31'd0, branch}, 32'd1);
        check_eq("beq_zero", {31'd0, alu_zero}, 32'd1);
        check_eq("beq_imm_src", {29'd0, imm_src}, 32'd2);
        apply(mk(7'd0, 3'b001, OpBranch), 32'd5, 32'd5, 32'd0);
        check_eq("bne_not", {31'd0, branch}, 32'd0);
        apply(mk(7'd0, 3'b100, OpBranch), 32'hFFFFFFFF, 32'd1, 32'd0);
        check_eq("blt_taken", {31'd0, branch}, 32'd1);
        apply(mk(7'd0, 3'b110, OpBranch), 32'hFFFFFFFF, 32'd1, 32'd0);
        check_eq("bltu_not", {31'd0, branch}, 32'd0);
        apply(mk(7'd0, 3'b101, OpBranch), 32'hFFFFFFFF, 32'd1, 32'd0);
        check_eq("bge_not", {31'd0, branch}, 32'd0);
        apply(mk(7'd0, 3'b000, OpJal), 32'd0, 32'd0, 32'd0);
        check_eq("jal_branch", {31'd0, branch}, 32'd1);
        check_eq("jal_wb", {30'd0, wrt_back_src}, 32'd2);
        check_eq("jal_imm_src", {29'd0, imm_src}, 32'd4);

        // Reset mid-program with a store pending: no write may occur
        debug_addr = 10'd4;
        apply(mk(7'd0, 3'b010, OpStore), 32'd0, 32'h00000BAD, 32'd4);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_rw", {31'd0, reg_write}, 32'd0);
        tick();
        tick();
        apply(mk(7'd0, 3'b000, OpJal), 32'd0, 32'd0, 32'd0);
        check_eq("mid_rst_branch", {31'd0, branch}, 32'd0);
        apply(mk(7'd0, 3'b000, OpR), 32'd1, 32'd2, 32'd0);
        rst = 1'b1;
        tick();
        check_eq("post_rst_word1", debug_data, 32'h22222222);
        check_eq("post_rst_add", alu_results, 32'd3);
        check_eq("post_rst_rw", {31'd0, reg_write}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
